pipeline_stall_ctrl: RTL and testbench
======================================

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: ADDR_W, default 32, PC and instruction width.
REQ-003 Parameter: CTRL_W, default 8, width of per-stage control bundles.
REQ-004 Parameter: MAX_STALL, default 2, longest legal run of consecutive Hold cycles.
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: rst  in  1  synchronous active-high reset.
REQ-007 Port: Hold  in  1  hazard stall request (freeze PC and IF/ID).
REQ-008 Port: ID_Flush  in  1  insert bubble into ID/EX.
REQ-009 Port: EX_Flush  in  1  insert bubble into EX/MEM.
REQ-010 Port: branch_taken  in  1  branch resolved taken in ID.
REQ-011 Port: branch_target  in  ADDR_W  redirect address.
REQ-012 Port: instr_in  in  ADDR_W  instruction memory read data for the current PC.
REQ-013 Port: id_ctrl_in  in  CTRL_W  decoded controls from ID.
REQ-014 Port: ex_ctrl_in  in  CTRL_W  controls leaving EX.
REQ-015 Port: PC  out  ADDR_W  fetch address.
REQ-016 Port: IF_ID_instr / IF_ID_pc4  out  ADDR_W each  IF/ID register contents.
REQ-017 Port: ID_EX_ctrl / EX_MEM_ctrl  out  CTRL_W each  registered stage controls.
REQ-018 Port: stall_cnt  out  16  saturating total count of Hold cycles.
REQ-019 Port: stall_err  out  1  sticky flag: Hold exceeded MAX_STALL consecutive cycles.

Function
REQ-020 All outputs SHALL be registered; all updates SHALL occur on the rising clk edge.
REQ-021 FSM states SHALL be WARM, RUN, STALL; WARM is entered on reset and lasts exactly one cycle, then RUN.
REQ-022 In WARM: PC += 4, IF/ID loads NOP (all zeros), and stage controls load zero regardless of inputs.
REQ-023 RUN, Hold=0, branch_taken=0: PC <= PC+4; IF_ID_instr <= instr_in; IF_ID_pc4 <= PC+4.
REQ-024 RUN, Hold=0, branch_taken=1: PC <= branch_target; IF/ID <= NOP, with IF_ID_pc4 <= 0 (one-cycle redirect penalty).
REQ-025 Hold=1: PC and IF/ID SHALL hold their values; branch_taken SHALL be ignored; state goes to STALL.
REQ-026 In STALL with Hold=0: the RUN rules apply that cycle and the state returns to RUN.
REQ-027 ID_EX_ctrl <= 0 when ID_Flush=1, else id_ctrl_in, independent of Hold.
REQ-028 EX_MEM_ctrl <= 0 when EX_Flush=1, else ex_ctrl_in, independent of Hold.
REQ-029 PC arithmetic SHALL be modulo 2^ADDR_W; 0xFFFFFFFC + 4 wraps to 0.
REQ-030 A run counter SHALL count consecutive Hold cycles and clear on any Hold=0 cycle.
REQ-031 stall_err SHALL set in the cycle the run counter would exceed MAX_STALL, and then stay set until reset.
REQ-032 stall_cnt SHALL increment once per Hold=1 cycle and saturate at 0xFFFF.
REQ-033 Simultaneous Hold=1 with ID_Flush=1 and EX_Flush=1 SHALL be honoured as: freeze PC and IF/ID, and bubble both ID/EX and EX/MEM.

Reset
REQ-034 rst SHALL take priority over all inputs, including mid-stall and mid-redirect.
REQ-035 On rst: PC=0, IF/ID=0, ID_EX_ctrl=0, EX_MEM_ctrl=0, stall_cnt=0, stall_err=0, run counter=0, state=WARM.

Structure
REQ-036 FSM state encodings, the NOP constant (0) and the PC increment (4) SHALL live in the shared pipeline package.
REQ-037 The saturating stall counter and run counter with the error flag SHALL be one sub-module, stall_monitor.

Verification
REQ-038 Reset then 3 idle cycles -> PC sequence 0, 4, 8, 12; IF/ID NOP in the WARM cycle, then instr_in.
REQ-039 PC=0x40, Hold=1 for 1 cycle with ID_Flush=1, id_ctrl_in=0xA5 -> PC stays 0x40, ID_EX_ctrl=0x00, stall_cnt=1, then PC=0x44.
REQ-040 PC=0x40, branch_taken=1, target=0x100 -> PC=0x100, IF_ID_instr=0; the same stimulus with Hold=1 -> PC stays 0x40.
REQ-041 Hold=1 for 3 consecutive cycles (MAX_STALL=2) -> stall_err rises on the 3rd cycle and stays 1 after Hold drops.
REQ-042 PC=0xFFFFFFFC, no hazard -> PC=0x00000000.
REQ-043 rst asserted during the second Hold cycle with EX_Flush=1 -> all outputs reset next edge, state WARM.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    StWarm  = 2'd0,
    StRun   = 2'd1,
    StStall = 2'd2
  } state_e;

  localparam int unsigned Nop       = 0;
  localparam int unsigned PcInc     = 4;
  localparam int unsigned StallCntW = 16;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and registered pipeline-register outputs of the stall controller.
interface pipeline_stall_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CTRL_W = 8
);
  logic              Hold;
  logic              ID_Flush;
  logic              EX_Flush;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] instr_in;
  logic [CTRL_W-1:0] id_ctrl_in;
  logic [CTRL_W-1:0] ex_ctrl_in;
  logic [ADDR_W-1:0] PC;
  logic [ADDR_W-1:0] IF_ID_instr;
  logic [ADDR_W-1:0] IF_ID_pc4;
  logic [CTRL_W-1:0] ID_EX_ctrl;
  logic [CTRL_W-1:0] EX_MEM_ctrl;
  logic [15:0]       stall_cnt;
  logic              stall_err;

  modport master (
    output Hold, ID_Flush, EX_Flush, branch_taken, branch_target, instr_in, id_ctrl_in,
           ex_ctrl_in,
    input  PC, IF_ID_instr, IF_ID_pc4, ID_EX_ctrl, EX_MEM_ctrl, stall_cnt, stall_err
  );

  modport slave (
    input  Hold, ID_Flush, EX_Flush, branch_taken, branch_target, instr_in, id_ctrl_in,
           ex_ctrl_in,
    output PC, IF_ID_instr, IF_ID_pc4, ID_EX_ctrl, EX_MEM_ctrl, stall_cnt, stall_err
  );
endinterface

// File: rtl/pipeline_stall_ctrl_stall_monitor.sv
// Saturating total-stall counter plus consecutive-stall run counter with sticky error.
module pipeline_stall_ctrl_stall_monitor
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned MAX_STALL = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  output logic [StallCntW-1:0] stall_cnt,
  output logic                 stall_err
);

  localparam int unsigned RunW = $clog2(MAX_STALL + 2);

  logic [RunW-1:0]      run_q, run_d;
  logic [StallCntW-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  always_comb begin
    run_d = '0;
    cnt_d = cnt_q;
    err_d = err_q;
    if (hold) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      // Run counter parks at MAX_STALL once the limit would be crossed.
      if (run_q >= RunW'(MAX_STALL)) begin
        run_d = run_q;
        err_d = 1'b1;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign stall_cnt = cnt_q;
  assign stall_err = err_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// PC / IF-ID / stage-control register update with hold, flush and branch redirect.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned CTRL_W    = 8,
  parameter int unsigned MAX_STALL = 2
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_stall_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [ADDR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic [CTRL_W-1:0] id_ex_q, id_ex_d;
  logic [CTRL_W-1:0] ex_mem_q, ex_mem_d;
  logic              hold_eff;

  assign pc_inc   = pc_q + ADDR_W'(PcInc);
  // The warm-up cycle ignores all inputs, so Hold is not counted there.
  assign hold_eff = bus.Hold && (state_q != StWarm);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    id_ex_d  = bus.ID_Flush ? '0 : bus.id_ctrl_in;
    ex_mem_d = bus.EX_Flush ? '0 : bus.ex_ctrl_in;
    unique case (state_q)
      StWarm: begin
        state_d  = StRun;
        pc_d     = pc_inc;
        instr_d  = ADDR_W'(Nop);
        pc4_d    = ADDR_W'(Nop);
        id_ex_d  = '0;
        ex_mem_d = '0;
      end
      StRun, StStall: begin
        if (bus.Hold) begin
          state_d = StStall;
        end else begin
          state_d = StRun;
          if (bus.branch_taken) begin
            pc_d    = bus.branch_target;
            instr_d = ADDR_W'(Nop);
            pc4_d   = ADDR_W'(Nop);
          end else begin
            pc_d    = pc_inc;
            instr_d = bus.instr_in;
            pc4_d   = pc_inc;
          end
        end
      end
      default: state_d = StWarm;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StWarm;
      pc_q     <= '0;
      instr_q  <= '0;
      pc4_q    <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
    end
  end

  pipeline_stall_ctrl_stall_monitor #(
    .MAX_STALL(MAX_STALL)
  ) stall_monitor (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold_eff),
    .stall_cnt(bus.stall_cnt),
    .stall_err(bus.stall_err)
  );

  assign bus.PC          = pc_q;
  assign bus.IF_ID_instr = instr_q;
  assign bus.IF_ID_pc4   = pc4_q;
  assign bus.ID_EX_ctrl  = id_ex_q;
  assign bus.EX_MEM_ctrl = ex_mem_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl.
module tb_pipeline_stall_ctrl;

  localparam logic [31:0] Instr = 32'hDEAD0001;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  pipeline_stall_ctrl_if #(.ADDR_W(32), .CTRL_W(8)) bus ();

  pipeline_stall_ctrl #(
    .ADDR_W   (32),
    .CTRL_W   (8),
    .MAX_STALL(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.Hold = 1'b0;
    bus.ID_Flush = 1'b0;
    bus.EX_Flush = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;
    bus.instr_in = Instr;
    bus.id_ctrl_in = 8'h33;
    bus.ex_ctrl_in = 8'h44;
    step();
    step();
    chk("rst_pc", bus.PC, 32'h0);
    chk("rst_instr", bus.IF_ID_instr, 32'h0);
    chk("rst_pc4", bus.IF_ID_pc4, 32'h0);
    chk("rst_idex", 32'(bus.ID_EX_ctrl), 32'h0);
    chk("rst_exmem", 32'(bus.EX_MEM_ctrl), 32'h0);
    chk("rst_cnt", 32'(bus.stall_cnt), 32'h0);
    chk("rst_err", 32'(bus.stall_err), 32'h0);

    // Warm-up cycle then normal fetch
    rst = 1'b0;
    step();
    chk("warm_pc", bus.PC, 32'h4);
    chk("warm_instr", bus.IF_ID_instr, 32'h0);
    chk("warm_idex", 32'(bus.ID_EX_ctrl), 32'h0);
    chk("warm_exmem", 32'(bus.EX_MEM_ctrl), 32'h0);
    step();
    chk("run1_pc", bus.PC, 32'h8);
    chk("run1_instr", bus.IF_ID_instr, Instr);
    chk("run1_pc4", bus.IF_ID_pc4, 32'h8);
    chk("run1_idex", 32'(bus.ID_EX_ctrl), 32'h33);
    chk("run1_exmem", 32'(bus.EX_MEM_ctrl), 32'h44);
    step();
    chk("run2_pc", bus.PC, 32'hC);
    chk("run2_pc4", bus.IF_ID_pc4, 32'hC);

    // Redirect to 0x40
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h40;
    step();
    chk("br40_pc", bus.PC, 32'h40);
    chk("br40_instr", bus.IF_ID_instr, 32'h0);
    chk("br40_pc4", bus.IF_ID_pc4, 32'h0);

    // One hold cycle with ID flush
    bus.branch_taken = 1'b0;
    bus.Hold = 1'b1;
    bus.ID_Flush = 1'b1;
    bus.id_ctrl_in = 8'hA5;
    step();
    chk("hold1_pc", bus.PC, 32'h40);
    chk("hold1_idex", 32'(bus.ID_EX_ctrl), 32'h0);
    chk("hold1_cnt", 32'(bus.stall_cnt), 32'h1);
    chk("hold1_instr", bus.IF_ID_instr, 32'h0);
    bus.Hold = 1'b0;
    bus.ID_Flush = 1'b0;
    step();
    chk("rel_pc", bus.PC, 32'h44);
    chk("rel_idex", 32'(bus.ID_EX_ctrl), 32'hA5);
    chk("rel_instr", bus.IF_ID_instr, Instr);
    chk("rel_pc4", bus.IF_ID_pc4, 32'h44);
    chk("rel_err", 32'(bus.stall_err), 32'h0);

    // Branch ignored under hold, then taken
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h40;
    step();
    chk("br40b_pc", bus.PC, 32'h40);
    bus.branch_target = 32'h100;
    bus.Hold = 1'b1;
    step();
    chk("brhold_pc", bus.PC, 32'h40);
    chk("brhold_cnt", 32'(bus.stall_cnt), 32'h2);
    bus.Hold = 1'b0;
    step();
    chk("br100_pc", bus.PC, 32'h100);
    chk("br100_instr", bus.IF_ID_instr, 32'h0);

    // Three consecutive holds trip the error flag
    bus.branch_taken = 1'b0;
    bus.Hold = 1'b1;
    step();
    chk("run1_err", 32'(bus.stall_err), 32'h0);
    step();
    chk("run2_err", 32'(bus.stall_err), 32'h0);
    chk("run2_cnt", 32'(bus.stall_cnt), 32'h4);
    step();
    chk("run3_err", 32'(bus.stall_err), 32'h1);
    chk("run3_cnt", 32'(bus.stall_cnt), 32'h5);
    chk("run3_pc", bus.PC, 32'h100);
    bus.Hold = 1'b0;
    step();
    chk("post_err", 32'(bus.stall_err), 32'h1);
    chk("post_pc", bus.PC, 32'h104);
    step();
    chk("post2_err", 32'(bus.stall_err), 32'h1);
    chk("post2_pc", bus.PC, 32'h108);

    // Hold with both flushes
    bus.Hold = 1'b1;
    bus.ID_Flush = 1'b1;
    bus.EX_Flush = 1'b1;
    bus.id_ctrl_in = 8'h5A;
    bus.ex_ctrl_in = 8'hC3;
    step();
    chk("both_pc", bus.PC, 32'h108);
    chk("both_idex", 32'(bus.ID_EX_ctrl), 32'h0);
    chk("both_exmem", 32'(bus.EX_MEM_ctrl), 32'h0);
    chk("both_cnt", 32'(bus.stall_cnt), 32'h6);
    bus.Hold = 1'b0;
    bus.ID_Flush = 1'b0;
    bus.EX_Flush = 1'b0;
    step();
    chk("unf_pc", bus.PC, 32'h10C);
    chk("unf_idex", 32'(bus.ID_EX_ctrl), 32'h5A);
    chk("unf_exmem", 32'(bus.EX_MEM_ctrl), 32'hC3);

    // PC wrap
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'hFFFF_FFFC;
    step();
    chk("top_pc", bus.PC, 32'hFFFF_FFFC);
    bus.branch_taken = 1'b0;
    step();
    chk("wrap_pc", bus.PC, 32'h0);
    chk("wrap_pc4", bus.IF_ID_pc4, 32'h0);
    chk("wrap_instr", bus.IF_ID_instr, Instr);

    // Reset during the second hold cycle
    bus.Hold = 1'b1;
    step();
    chk("pre_rst_cnt", 32'(bus.stall_cnt), 32'h7);
    bus.EX_Flush = 1'b1;
    rst = 1'b1;
    step();
    chk("mid_rst_pc", bus.PC, 32'h0);
    chk("mid_rst_instr", bus.IF_ID_instr, 32'h0);
    chk("mid_rst_pc4", bus.IF_ID_pc4, 32'h0);
    chk("mid_rst_idex", 32'(bus.ID_EX_ctrl), 32'h0);
    chk("mid_rst_exmem", 32'(bus.EX_MEM_ctrl), 32'h0);
    chk("mid_rst_cnt", 32'(bus.stall_cnt), 32'h0);
    chk("mid_rst_err", 32'(bus.stall_err), 32'h0);
    rst = 1'b0;
    bus.Hold = 1'b0;
    bus.EX_Flush = 1'b0;
    step();
    chk("rewarm_pc", bus.PC, 32'h4);
    chk("rewarm_instr", bus.IF_ID_instr, 32'h0);
    step();
    chk("rerun_pc", bus.PC, 32'h8);
    chk("rerun_instr", bus.IF_ID_instr, Instr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
